timer_bank: RTL and testbench

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank.sv | 100 ++++++++++
 tb/tb_timer_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// Bank of NCH independent one-shot timers with shadowed periods,
// per-channel retrigger mode, abort, and natural-expiry DONE pulses.
module timer_bank #(
    parameter int NCH     = 4,
    parameter int W       = 16,
    parameter int DEF_PER = 255,
    localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk_i,
    input  logic            r_n_i,
    input  logic [NCH-1:0]  trg_i,
    input  logic [NCH-1:0]  mode_i,
    input  logic [NCH-1:0]  abort_i,
    input  logic            per_we_i,
    input  logic [SELW-1:0] per_sel_i,
    input  logic [W-1:0]    per_data_i,
    output logic [NCH-1:0]  out_o,
    output logic [NCH-1:0]  done_o,
    output logic            busy_o
);

    logic [W-1:0]   sp_q  [NCH];
    logic [W-1:0]   sp_d  [NCH];
    logic [W-1:0]   ap_q  [NCH];
    logic [W-1:0]   ap_d  [NCH];
    logic [W-1:0]   cnt_q [NCH];
    logic [W-1:0]   cnt_d [NCH];
    logic [NCH-1:0] run_q, run_d;
    logic [NCH-1:0] done_q, done_d;
    logic           busy_q;

    // State register: run_q is the per-channel IDLE/RUN state bit.
    always_ff @(posedge clk_i) begin
        if (!r_n_i) begin
            for (int i = 0; i < NCH; i++) begin
                sp_q[i]  <= W'(DEF_PER);
                ap_q[i]  <= W'(DEF_PER);
                cnt_q[i] <= '0;
            end
            run_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sp_q[i]  <= sp_d[i];
                ap_q[i]  <= ap_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            run_q  <= run_d;
            done_q <= done_d;
            busy_q <= |run_d;
        end
    end

    // Next state. Triggers read sp_q, so a same-edge period write lands on the next term.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sp_d[i]   = sp_q[i];
            ap_d[i]   = ap_q[i];
            cnt_d[i]  = cnt_q[i];
            run_d[i]  = run_q[i];
            done_d[i] = 1'b0;
            if (per_we_i && per_sel_i == SELW'(i)) begin
                sp_d[i] = per_data_i;
            end
            if (abort_i[i]) begin
                run_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (!run_q[i]) begin
                if (trg_i[i] && sp_q[i] != '0) begin
                    run_d[i] = 1'b1;
                    ap_d[i]  = sp_q[i];
                    cnt_d[i] = '0;
                end
            end else if (trg_i[i] && mode_i[i]) begin
                // Retrigger beats expiry; a zero period behaves like abort.
                if (sp_q[i] == '0) begin
                    run_d[i] = 1'b0;
                    cnt_d[i] = '0;
                end else begin
                    ap_d[i]  = sp_q[i];
                    cnt_d[i] = '0;
                end
            end else if (cnt_q[i] == ap_q[i] - W'(1)) begin
                run_d[i]  = 1'b0;
                cnt_d[i]  = '0;
                done_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + W'(1);
            end
        end
    end

    always_comb begin
        out_o  = run_q;
        done_o = done_q;
        busy_o = busy_q;
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: table of per-cycle vectors plus a
// hand-written reset-mid-term / default-period sequence.
module tb_timer_bank;

    logic        clk;
    logic        r_n;
    logic [3:0]  trg, mode, abort;
    logic        per_we;
    logic [1:0]  per_sel;
    logic [15:0] per_data;
    logic [3:0]  out_w, done_w;
    logic        busy_w;

    int checks = 0;
    int errors = 0;

    timer_bank #(.NCH(4), .W(16), .DEF_PER(255)) dut (
        .clk_i      (clk),
        .r_n_i      (r_n),
        .trg_i      (trg),
        .mode_i     (mode),
        .abort_i    (abort),
        .per_we_i   (per_we),
        .per_sel_i  (per_sel),
        .per_data_i (per_data),
        .out_o      (out_w),
        .done_o     (done_w),
        .busy_o     (busy_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r;
        logic [3:0]  trg;
        logic [3:0]  mode;
        logic [3:0]  abort;
        logic        we;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [3:0]  eo;
        logic [3:0]  ed;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] m_mode;

    task automatic add(input logic r, input logic [3:0] t, input logic [3:0] a,
                       input logic we, input logic [1:0] sel, input logic [15:0] data,
                       input logic [3:0] eo, input logic [3:0] ed);
        vec_t v;
        v.r = r; v.trg = t; v.mode = m_mode; v.abort = a;
        v.we = we; v.sel = sel; v.data = data; v.eo = eo; v.ed = ed;
        vq.push_back(v);
    endtask

    task automatic idle(input logic [3:0] eo, input logic [3:0] ed);
        add(1'b1, 4'b0, 4'b0, 1'b0, 2'd0, 16'd0, eo, ed);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] data,
                      input logic [3:0] eo, input logic [3:0] ed);
        add(1'b1, 4'b0, 4'b0, 1'b1, sel, data, eo, ed);
    endtask

    task automatic tg(input logic [3:0] t, input logic [3:0] eo, input logic [3:0] ed);
        add(1'b1, t, 4'b0, 1'b0, 2'd0, 16'd0, eo, ed);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build();
        m_mode = 4'b0000;
        // Reset, then basic 5-cycle pulse on channel 0
        add(1'b0, 4'b0, 4'b0, 1'b0, 2'd0, 16'd0, 4'b0, 4'b0);
        wr(2'd0, 16'd5, 4'b0, 4'b0);
        tg(4'b0001, 4'b0001, 4'b0);
        repeat (4) idle(4'b0001, 4'b0);
        idle(4'b0, 4'b0001);
        idle(4'b0, 4'b0);
        // Retriggerable channel 1, period 4, triggers at t and t+2
        m_mode = 4'b0010;
        wr(2'd1, 16'd4, 4'b0, 4'b0);
        tg(4'b0010, 4'b0010, 4'b0);
        idle(4'b0010, 4'b0);
        tg(4'b0010, 4'b0010, 4'b0);
        repeat (3) idle(4'b0010, 4'b0);
        idle(4'b0, 4'b0010);
        idle(4'b0, 4'b0);
        // Same pattern non-retriggerable
        m_mode = 4'b0000;
        tg(4'b0010, 4'b0010, 4'b0);
        idle(4'b0010, 4'b0);
        tg(4'b0010, 4'b0010, 4'b0);
        idle(4'b0010, 4'b0);
        idle(4'b0, 4'b0010);
        idle(4'b0, 4'b0);
        // Trigger on the expiry edge, channel 2 period 3
        m_mode = 4'b0100;
        wr(2'd2, 16'd3, 4'b0, 4'b0);
        tg(4'b0100, 4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        tg(4'b0100, 4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        idle(4'b0, 4'b0100);
        idle(4'b0, 4'b0);
        m_mode = 4'b0000;
        tg(4'b0100, 4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        idle(4'b0100, 4'b0);
        tg(4'b0100, 4'b0, 4'b0100);
        idle(4'b0, 4'b0);
        // Abort with shadow write mid-term, channel 3
        wr(2'd3, 16'd10, 4'b0, 4'b0);
        tg(4'b1000, 4'b1000, 4'b0);
        idle(4'b1000, 4'b0);
        idle(4'b1000, 4'b0);
        wr(2'd3, 16'd2, 4'b1000, 4'b0);
        idle(4'b1000, 4'b0);
        idle(4'b1000, 4'b0);
        add(1'b1, 4'b0, 4'b1000, 1'b0, 2'd0, 16'd0, 4'b0, 4'b0);
        idle(4'b0, 4'b0);
        tg(4'b1000, 4'b1000, 4'b0);
        idle(4'b1000, 4'b0);
        idle(4'b0, 4'b1000);
        idle(4'b0, 4'b0);
        // Abort beats a trigger from idle
        add(1'b1, 4'b1000, 4'b1000, 1'b0, 2'd0, 16'd0, 4'b0, 4'b0);
        // Zero period: no start; retrigger with zero period acts as abort
        wr(2'd3, 16'd0, 4'b0, 4'b0);
        tg(4'b1000, 4'b0, 4'b0);
        m_mode = 4'b1000;
        wr(2'd3, 16'd5, 4'b0, 4'b0);
        tg(4'b1000, 4'b1000, 4'b0);
        wr(2'd3, 16'd0, 4'b1000, 4'b0);
        tg(4'b1000, 4'b0, 4'b0);
        idle(4'b0, 4'b0);
        m_mode = 4'b0000;
        // Same-edge write and trigger uses old period (5), next term uses 2
        add(1'b1, 4'b0001, 4'b0, 1'b1, 2'd0, 16'd2, 4'b0001, 4'b0);
        repeat (4) idle(4'b0001, 4'b0);
        idle(4'b0, 4'b0001);
        tg(4'b0001, 4'b0001, 4'b0);
        idle(4'b0001, 4'b0);
        idle(4'b0, 4'b0001);
        idle(4'b0, 4'b0);
        // Independence: periods 1..4, simultaneous triggers
        wr(2'd0, 16'd1, 4'b0, 4'b0);
        wr(2'd1, 16'd2, 4'b0, 4'b0);
        wr(2'd2, 16'd3, 4'b0, 4'b0);
        wr(2'd3, 16'd4, 4'b0, 4'b0);
        tg(4'b1111, 4'b1111, 4'b0);
        idle(4'b1110, 4'b0001);
        idle(4'b1100, 4'b0010);
        idle(4'b1000, 4'b0100);
        idle(4'b0000, 4'b1000);
        idle(4'b0, 4'b0);
        // All running, then reset (with triggers held) mid-term
        wr(2'd0, 16'd10, 4'b0, 4'b0);
        wr(2'd1, 16'd10, 4'b0, 4'b0);
        wr(2'd2, 16'd10, 4'b0, 4'b0);
        wr(2'd3, 16'd10, 4'b0, 4'b0);
        tg(4'b1111, 4'b1111, 4'b0);
        idle(4'b1111, 4'b0);
        add(1'b0, 4'b1111, 4'b0, 1'b0, 2'd0, 16'd0, 4'b0, 4'b0);
    endtask

    initial begin
        int n;
        vec_t v;
        build();
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            r_n = v.r; trg = v.trg; mode = v.mode; abort = v.abort;
            per_we = v.we; per_sel = v.sel; per_data = v.data;
            @(negedge clk);
            check($sformatf("vec%0d out/done/busy", i),
                  {23'd0, out_w, done_w, busy_w},
                  {23'd0, v.eo, v.ed, |v.eo});
        end
        // After reset the period is back at its default of 255
        r_n = 1'b1; trg = 4'b0001; mode = 4'b0; abort = 4'b0;
        per_we = 1'b0; per_sel = 2'd0; per_data = 16'd0;
        @(negedge clk);
        trg = 4'b0;
        n = 0;
        while (out_w[0] === 1'b1 && n < 300) begin
            check("default_pulse_no_early_done", {28'd0, done_w}, 32'd0);
            n++;
            @(negedge clk);
        end
        check("default_pulse_len", n, 32'd255);
        check("default_pulse_done", {27'd0, out_w, busy_w, done_w[0]}, 32'd1);
        check("default_pulse_done_all", {28'd0, done_w}, 32'd1);
        @(negedge clk);
        check("default_pulse_done_clear", {27'd0, out_w, done_w[0]}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
